// File: rtl/shift_decoder.sv
// shift_decoder -- receive-side checker for a WIDTH-bit Johnson (twisted-ring)
// shift counter. Each valid sample is decoded to a phase index (0..2*WIDTH-1).
// Illegal codes are flagged. The checker verifies that the sequence advances by
// one phase per sample and locks once LOCK_CNT consecutive in-sequence codes
// have been seen. While locked, any break in the sequence produces a one-cycle
// err pulse and bumps a saturating fault counter.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; overrides code_valid
//   code_in    in   [WIDTH-1:0] sampled counter value
//   code_valid in   code_in is a new sample this cycle
//   index      out  [IDX_W-1:0] phase of the last legal sample
//   legal      out  last sample was a legal Johnson code
//   locked     out  checker is in LOCKED
//   err        out  one-cycle pulse on a fault while LOCKED
//   err_count  out  [7:0] saturating fault counter
//
// Configuration macro: SHIFT_DECODER_HOLD_EN -- when defined, a sample that
// repeats the current phase (stalled counter) is accepted without effect in
// CONFIRM/LOCKED. When undefined, a repeat is out of sequence.
module shift_decoder #(
  parameter int WIDTH    = 8,
  parameter int IDX_W    = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic [IDX_W-1:0] index,
  output logic             legal,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam int unsigned W_U   = WIDTH;
  localparam int unsigned SEQ_N = 2 * WIDTH;
  localparam int          RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               legal_q, legal_d;
  logic               err_q, err_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [RUN_W-1:0]   run_q, run_d;

  logic               dec_legal;
  logic [IDX_W-1:0]   dec_phase;
  logic [IDX_W-1:0]   exp_phase;
  logic               in_seq;
  logic               stall;
  logic [RUN_W-1:0]   run_inc;

  // Phase k <= WIDTH: k ones filled from the LSB.
  // Phase k >  WIDTH: (k-WIDTH) zeros at the bottom, ones above.
  function automatic logic [WIDTH-1:0] johnson_code(input int unsigned k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k <= W_U) return ones >> (W_U - k);
    else          return ~(ones >> (SEQ_N - k));
  endfunction

  always_comb begin
    dec_legal = 1'b0;
    dec_phase = '0;
    for (int unsigned k = 0; k < SEQ_N; k++) begin
      if (code_in == johnson_code(k)) begin
        dec_legal = 1'b1;
        dec_phase = IDX_W'(k);
      end
    end
  end

  assign exp_phase = (index_q == IDX_W'(SEQ_N - 1)) ? '0 : index_q + IDX_W'(1);
  assign in_seq    = dec_legal && (dec_phase == exp_phase);
  assign run_inc   = run_q + RUN_W'(1);

`ifdef SHIFT_DECODER_HOLD_EN
  assign stall = dec_legal && (dec_phase == index_q);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    legal_d     = legal_q;
    run_d       = run_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    if (code_valid) begin
      legal_d = dec_legal;
      if (dec_legal) index_d = dec_phase;

      unique case (state_q)
        S_HUNT: begin
          if (dec_legal) begin
            run_d   = RUN_W'(1);
            state_d = (LOCK_CNT == 1) ? S_LOCKED : S_CONFIRM;
          end
        end

        S_CONFIRM: begin
          if (stall) begin
            // stalled counter: accepted, run not advanced
          end else if (in_seq) begin
            run_d = run_inc;
            if (run_inc >= RUN_W'(LOCK_CNT)) state_d = S_LOCKED;
          end else if (dec_legal) begin
            run_d = RUN_W'(1);
            if (LOCK_CNT == 1) state_d = S_LOCKED;
          end else begin
            state_d = S_HUNT;
          end
        end

        S_LOCKED: begin
          if (!(stall || in_seq)) begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            // the faulting sample itself seeds re-acquisition
            run_d   = RUN_W'(1);
            state_d = dec_legal ? S_CONFIRM : S_HUNT;
          end
        end

        default: state_d = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HUNT;
      index_q     <= '0;
      legal_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      legal_q     <= legal_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      run_q       <= run_d;
    end
  end

  assign index     = index_q;
  assign legal     = legal_q;
  assign locked    = (state_q == S_LOCKED);
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_shift_decoder.sv
module tb_shift_decoder;

  localparam int W  = 8;
  localparam int IW = 4;
  localparam int LC = 3;
`ifdef SHIFT_DECODER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          code_valid = 1'b0;
  logic [W-1:0]  code_in = '0;
  logic [IW-1:0] index;
  logic          legal, locked, err;
  logic [7:0]    err_count;

  shift_decoder #(.WIDTH(W), .IDX_W(IW), .LOCK_CNT(LC)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .index      (index),
    .legal      (legal),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count)
  );

  always #2 clk = ~clk;

  typedef struct {
    int idx;
    int lg;
    int lk;
    int er;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  // reference model state: 0=hunt 1=confirm 2=locked
  int m_state = 0, m_idx = 0, m_run = 0, m_legal = 0, m_err = 0, m_cnt = 0;

  function automatic logic [W-1:0] code_of(input int k);
    logic [W-1:0] c;
    for (int b = 0; b < W; b++) c[b] = (k <= W) ? (b < k) : (b >= k - W);
    return c;
  endfunction

  function automatic int phase_of(input logic [W-1:0] c);
    for (int k = 0; k < 2 * W; k++) if (code_of(k) == c) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model(input bit rst, input bit vld, input logic [W-1:0] c);
    int p, nxt;
    bit hold;
    exp_t e;
    m_err = 0;
    if (rst) begin
      m_state = 0; m_idx = 0; m_run = 0; m_legal = 0; m_cnt = 0;
    end else if (vld) begin
      p     = phase_of(c);
      nxt   = (m_idx + 1) % (2 * W);
      hold  = HOLD && (p == m_idx) && (m_state != 0);
      m_legal = (p >= 0);
      if (m_state == 0) begin
        if (p >= 0) begin m_run = 1; m_state = (LC == 1) ? 2 : 1; end
      end else if (hold) begin
        m_run = m_run;
      end else if (p == nxt) begin
        if (m_state == 1) begin m_run++; if (m_run >= LC) m_state = 2; end
      end else if (m_state == 1) begin
        if (p >= 0) begin m_run = 1; if (LC == 1) m_state = 2; end
        else m_state = 0;
      end else begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
        m_run = 1;
        m_state = (p >= 0) ? 1 : 0;
      end
      if (p >= 0) m_idx = p;
    end
    e.idx = m_idx; e.lg = m_legal; e.lk = (m_state == 2); e.er = m_err; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit vld, input logic [W-1:0] c);
    exp_t e;
    model(rst, vld, c);
    reset = rst; code_valid = vld; code_in = c;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("sb_index",  32'(index),     e.idx);
      chk("sb_legal",  32'(legal),     e.lg);
      chk("sb_locked", 32'(locked),    e.lk);
      chk("sb_err",    32'(err),       e.er);
      chk("sb_cnt",    32'(err_count), e.cnt);
    end
  endtask

  task automatic ph(input int k);
    drive(1'b0, 1'b1, code_of(k));
  endtask

  initial begin
    int exp_cnt;
    int cur;

    // reset state
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    chk("rst_index", 32'(index), 0);
    chk("rst_legal", 32'(legal), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(err_count), 0);

    // full cycle with wrap
    for (int i = 0; i <= 16; i++) begin
      ph(i % 16);
      chk("t1_index", 32'(index), 32'(i % 16));
      chk("t1_locked", 32'(locked), 32'(i >= 2));
      chk("t1_err", 32'(err), 0);
    end

    // idle cycle holds everything
    drive(1'b0, 1'b0, 8'hAA);
    chk("idle_index", 32'(index), 0);
    chk("idle_locked", 32'(locked), 1);
    chk("idle_legal", 32'(legal), 1);

    // repeated code
    for (int k = 1; k <= 5; k++) ph(k);
    ph(6);
    chk("t2_first_index", 32'(index), 6);
    chk("t2_first_err", 32'(err), 0);
    ph(6);
    exp_cnt = HOLD ? 0 : 1;
    chk("t2_rep_err", 32'(err), HOLD ? 0 : 1);
    chk("t2_rep_locked", 32'(locked), HOLD ? 1 : 0);
    chk("t2_rep_cnt", 32'(err_count), 32'(exp_cnt));
    ph(7); ph(8); ph(9);
    chk("t2_relock", 32'(locked), 1);

    // illegal code while locked
    drive(1'b0, 1'b1, 8'h55);
    exp_cnt++;
    chk("t3_legal", 32'(legal), 0);
    chk("t3_err", 32'(err), 1);
    chk("t3_cnt", 32'(err_count), 32'(exp_cnt));
    chk("t3_locked", 32'(locked), 0);
    chk("t3_index", 32'(index), 9);

    // skip from phase 3 to phase 6
    ph(0); ph(1); ph(2); ph(3);
    chk("t4_pre_locked", 32'(locked), 1);
    ph(6);
    exp_cnt++;
    chk("t4_err", 32'(err), 1);
    chk("t4_locked", 32'(locked), 0);
    chk("t4_cnt", 32'(err_count), 32'(exp_cnt));
    chk("t4_index", 32'(index), 6);
    ph(7); ph(8); ph(9);
    chk("t4_relock", 32'(locked), 1);
    chk("t4_err_after", 32'(err), 0);

    // reset mid-lock with code_valid high
    drive(1'b1, 1'b1, code_of(10));
    chk("t5_index", 32'(index), 0);
    chk("t5_legal", 32'(legal), 0);
    chk("t5_locked", 32'(locked), 0);
    chk("t5_err", 32'(err), 0);
    chk("t5_cnt", 32'(err_count), 0);
    ph(11); ph(12);
    chk("t5_not_yet", 32'(locked), 0);
    ph(13);
    chk("t5_relock", 32'(locked), 1);

    // saturation of the fault counter
    cur = 13;
    for (int n = 0; n < 260; n++) begin
      cur = (cur + 2) % 16;
      ph(cur);
      chk("t6_err", 32'(err), 1);
      cur = (cur + 1) % 16; ph(cur);
      cur = (cur + 1) % 16; ph(cur);
    end
    chk("t6_cnt_sat", 32'(err_count), 255);
    chk("t6_locked", 32'(locked), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
